// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-memory arbiter: bus widths, arbiter
// state encoding and requester identifiers.
package mem_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick between the I-cache and D-cache requests.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
  import mem_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic gnt_vld,
  output logic gnt_id
);

  // Single requester wins outright; a tie goes to the one not served last.
  always_comb begin
    gnt_vld = req_i | req_d;
    gnt_id  = REQ_I;
    if (req_i && req_d) begin
      gnt_id = (last == REQ_D) ? REQ_I : REQ_D;
    end else if (req_d) begin
      gnt_id = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one block-memory port between the I-cache and D-cache.
// One transaction is owned at a time; the winner's command is latched and
// mem_ready is routed back only to the owner.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to add the arb_timeout flag
// and abandon a transaction after TIMEOUT_CYCLES busy cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W         = mem_pkg::ADDR_W,
  parameter int DATA_W         = mem_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic [DATA_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              arb_timeout
`endif
);

  arb_state_e        state_q, state_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              gnt_vld;
  logic              gnt_id;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  assign arb_timeout = timeout_q;
`endif

  rr_arb2 u_rr_arb2 (
    .req_i   (ic_mem_read),
    .req_d   (dc_mem_read | dc_mem_write),
    .last    (last_q),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // State register and latched command; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= REQ_D;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next state: grant in IDLE, release on mem_ready (no grant that cycle).
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_d    = last_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          last_d = gnt_id;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d  = '0;
`endif
          if (gnt_id == REQ_I) begin
            state_d = BUSY_I;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
            addr_d  = ic_mem_addr;
            wdata_d = '0;
          end else begin
            // A combined read+write is served as the write; the read is reissued.
            state_d = BUSY_D;
            rd_d    = dc_mem_read & ~dc_mem_write;
            wr_d    = dc_mem_write;
            addr_d  = dc_mem_addr;
            wdata_d = dc_mem_wdata;
          end
        end
      end
      BUSY_I, BUSY_D: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        if (mem_ready) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q + 16'd1 == TIMEOUT_LIM) begin
          state_d   = IDLE;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          timeout_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // Outputs: strobes drop in the ready cycle; ready goes only to the owner.
  always_comb begin
    mem_read     = rd_q & ~mem_ready;
    mem_write    = wr_q & ~mem_ready;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    ic_mem_ready = mem_ready & (state_q == BUSY_I);
    dc_mem_ready = mem_ready & (state_q == BUSY_D);
    ic_mem_rdata = mem_rdata;
    dc_mem_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single-requester
// transactions plus hand-written sequences for ties, waiting requesters,
// request drop, stray ready, async reset and (optionally) the watchdog.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          proc_reset;
  logic          ic_mem_read;
  logic [AW-1:0] ic_mem_addr;
  logic [DW-1:0] ic_mem_rdata;
  logic          ic_mem_ready;
  logic          dc_mem_read;
  logic          dc_mem_write;
  logic [AW-1:0] dc_mem_addr;
  logic [DW-1:0] dc_mem_wdata;
  logic [DW-1:0] dc_mem_rdata;
  logic          dc_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
`ifdef MEM_ARB_TIMEOUT_EN
  logic          arb_timeout;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .ic_mem_read  (ic_mem_read),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_rdata (ic_mem_rdata),
    .ic_mem_ready (ic_mem_ready),
    .dc_mem_read  (dc_mem_read),
    .dc_mem_write (dc_mem_write),
    .dc_mem_addr  (dc_mem_addr),
    .dc_mem_wdata (dc_mem_wdata),
    .dc_mem_rdata (dc_mem_rdata),
    .dc_mem_ready (dc_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .arb_timeout  (arb_timeout)
`endif
  );

  typedef struct {
    logic          ic_rdy;
    logic          dc_rdy;
    logic [DW-1:0] rdata;
  } sb_t;

  typedef struct {
    logic          ic_rd;
    logic          dc_rd;
    logic          dc_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic [DW-1:0] rdata;
    logic          exp_rd;
    logic          exp_wr;
    logic [DW-1:0] exp_wdata;
    logic          exp_ic;
    logic          exp_dc;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[5];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push_sb(input logic ic_rdy, input logic dc_rdy, input logic [DW-1:0] rdata);
    sb_t e;
    e.ic_rdy = ic_rdy;
    e.dc_rdy = dc_rdy;
    e.rdata  = rdata;
    sb_q.push_back(e);
  endtask

  // Called at a negedge: memory completes now; the ready edge follows.
  task automatic mem_respond();
    sb_t e;
    if (sb_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL sb_empty: got ready with no expected transaction, expected one queued");
      mem_rdata = '0;
      mem_ready = 1'b1;
      #1;
    end else begin
      e = sb_q.pop_front();
      mem_rdata = e.rdata;
      mem_ready = 1'b1;
      #1;
      chk("ready_cyc_read_low",  mem_read,     '0);
      chk("ready_cyc_write_low", mem_write,    '0);
      chk("ic_ready_route",      ic_mem_ready, e.ic_rdy);
      chk("dc_ready_route",      dc_mem_ready, e.dc_rdy);
      chk("ic_rdata",            ic_mem_rdata, e.rdata);
      chk("dc_rdata",            dc_mem_rdata, e.rdata);
    end
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  task automatic clear_reqs();
    ic_mem_read  = 1'b0;
    dc_mem_read  = 1'b0;
    dc_mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // {ic_rd, dc_rd, dc_wr, addr, wdata, lat, rdata, exp_rd, exp_wr, exp_wdata, exp_ic, exp_dc}
    vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, 128'hDEAD, 3, {32{4'hA, 4'h5}}, 1'b1, 1'b0, 128'h0,    1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 28'h0000020, 128'h0,    2, {32{4'h5, 4'hA}}, 1'b1, 1'b0, 128'h0,    1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 28'h0000003, 128'h1234, 4, 128'h77,          1'b0, 1'b1, 128'h1234, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 28'h0000007, 128'hBEEF, 1, 128'h99,          1'b0, 1'b1, 128'hBEEF, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 128'h5,    1, {DW{1'b1}},       1'b1, 1'b0, 128'h0,    1'b1, 1'b0};

    proc_reset   = 1'b1;
    clear_reqs();
    ic_mem_addr  = '0;
    dc_mem_addr  = '0;
    dc_mem_wdata = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    #1;
    chk("rst_mem_read",  mem_read,     '0);
    chk("rst_mem_write", mem_write,    '0);
    chk("rst_mem_addr",  mem_addr,     '0);
    chk("rst_mem_wdata", mem_wdata,    '0);
    chk("rst_ic_ready",  ic_mem_ready, '0);
    chk("rst_dc_ready",  dc_mem_ready, '0);
    ic_mem_read = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_held_read", mem_read, '0);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("rst_timeout", arb_timeout, '0);
`endif
    ic_mem_read = 1'b0;
    proc_reset  = 1'b0;
    @(negedge clk);

    // Table of single-requester transactions
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ic_mem_read  = vecs[i].ic_rd;
      dc_mem_read  = vecs[i].dc_rd;
      dc_mem_write = vecs[i].dc_wr;
      ic_mem_addr  = vecs[i].ic_rd ? vecs[i].addr : ~vecs[i].addr;
      dc_mem_addr  = vecs[i].ic_rd ? ~vecs[i].addr : vecs[i].addr;
      dc_mem_wdata = vecs[i].wdata;
      push_sb(vecs[i].exp_ic, vecs[i].exp_dc, vecs[i].rdata);
      @(negedge clk);
      chk($sformatf("v%0d_mem_read", i),  mem_read,  vecs[i].exp_rd);
      chk($sformatf("v%0d_mem_write", i), mem_write, vecs[i].exp_wr);
      chk($sformatf("v%0d_mem_addr", i),  mem_addr,  vecs[i].addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
      repeat (vecs[i].lat - 1) @(negedge clk);
      mem_respond();
      clear_reqs();
    end

    // Tie right after reset: I first, idle gap, then D; next tie to I again
    @(negedge clk);
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset   = 1'b0;
    ic_mem_read  = 1'b1;
    ic_mem_addr  = 28'h10;
    dc_mem_read  = 1'b1;
    dc_mem_addr  = 28'h20;
    dc_mem_wdata = '0;
    push_sb(1'b1, 1'b0, 128'h111);
    @(negedge clk);
    chk("tie1_addr", mem_addr, 28'h10);
    @(negedge clk);
    mem_respond();
    ic_mem_read = 1'b0;
    push_sb(1'b0, 1'b1, 128'h222);
    chk("tie1_gap", mem_read, '0);
    @(negedge clk);
    chk("tie1_second_addr", mem_addr, 28'h20);
    chk("tie1_second_read", mem_read, 1'b1);
    mem_respond();
    dc_mem_read = 1'b0;
    @(negedge clk);
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h11;
    dc_mem_read = 1'b1;
    dc_mem_addr = 28'h21;
    push_sb(1'b1, 1'b0, 128'h333);
    @(negedge clk);
    chk("tie2_addr", mem_addr, 28'h11);
    mem_respond();
    ic_mem_read = 1'b0;
    push_sb(1'b0, 1'b1, 128'h444);
    @(negedge clk);
    chk("tie2_second_addr", mem_addr, 28'h21);
    mem_respond();
    dc_mem_read = 1'b0;

    // D-cache write with an I-cache request arriving mid-write
    @(negedge clk);
    dc_mem_write = 1'b1;
    dc_mem_addr  = 28'h3;
    dc_mem_wdata = 128'h1234;
    push_sb(1'b0, 1'b1, 128'h555);
    @(negedge clk);
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h40;
    push_sb(1'b1, 1'b0, 128'h666);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("wr_hold_write", mem_write, 1'b1);
      chk("wr_hold_wdata", mem_wdata, 128'h1234);
      chk("wr_hold_addr",  mem_addr,  28'h3);
      chk("wr_hold_read",  mem_read,  '0);
    end
    mem_respond();
    dc_mem_write = 1'b0;
    @(negedge clk);
    chk("wait_grant_addr", mem_addr, 28'h40);
    chk("wait_grant_read", mem_read, 1'b1);
    mem_respond();
    ic_mem_read = 1'b0;

    // Owner drops its request after one cycle
    @(negedge clk);
    dc_mem_read = 1'b1;
    dc_mem_addr = 28'h50;
    push_sb(1'b0, 1'b1, 128'h777);
    @(negedge clk);
    dc_mem_read = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("drop_hold_read", mem_read, 1'b1);
      chk("drop_hold_addr", mem_addr, 28'h50);
    end
    mem_respond();

    // Stray mem_ready in IDLE is not forwarded
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("idle_ready_ic", ic_mem_ready, '0);
    chk("idle_ready_dc", dc_mem_ready, '0);
    @(negedge clk);
    mem_ready = 1'b0;

    // Async reset during BUSY_D
    @(negedge clk);
    dc_mem_read = 1'b1;
    dc_mem_addr = 28'h60;
    @(negedge clk);
    chk("pre_rst_read", mem_read, 1'b1);
    proc_reset = 1'b1;
    mem_ready  = 1'b1;
    #1;
    chk("async_rst_read",  mem_read,     '0);
    chk("async_rst_write", mem_write,    '0);
    chk("async_rst_dc_rdy", dc_mem_ready, '0);
    chk("async_rst_addr",  mem_addr,     '0);
    dc_mem_read = 1'b0;
    @(negedge clk);
    proc_reset = 1'b0;
    mem_ready  = 1'b0;
    @(negedge clk);
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h70;
    dc_mem_read = 1'b1;
    dc_mem_addr = 28'h71;
    push_sb(1'b1, 1'b0, 128'h888);
    @(negedge clk);
    chk("post_rst_tie_addr", mem_addr, 28'h70);
    mem_respond();
    clear_reqs();

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog with memory never ready
    @(negedge clk);
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h80;
    @(negedge clk);
    chk("to_read", mem_read, 1'b1);
    ic_mem_read = 1'b0;
    repeat (7) @(negedge clk);
    chk("to_before_flag", arb_timeout, '0);
    chk("to_before_read", mem_read, 1'b1);
    @(negedge clk);
    chk("to_flag", arb_timeout, 1'b1);
    chk("to_read_drop", mem_read, '0);
    @(negedge clk);
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h90;
    push_sb(1'b1, 1'b0, 128'h999);
    @(negedge clk);
    chk("to_next_addr", mem_addr, 28'h90);
    mem_respond();
    ic_mem_read = 1'b0;
    chk("to_sticky", arb_timeout, 1'b1);
`endif

    chk("sb_drained", 128'(sb_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
